// File: rtl/dsp_pipe_reg_if.sv
// dsp_pipe_reg_if: operand-side bus of the input pipeline register (controls, data, valid, occupancy).
interface dsp_pipe_reg_if #(
    parameter int IN_WIDTH  = 18,
    parameter int OUT_WIDTH = 18,
    parameter int OCC_W     = 1
);
    logic                 ce;
    logic                 flush;
    logic [IN_WIDTH-1:0]  d;
    logic                 d_vld;
    logic [OUT_WIDTH-1:0] q;
    logic                 q_vld;
    logic [OCC_W-1:0]     occ;
    modport master (output ce, flush, d, d_vld, input q, q_vld, occ);
    modport slave  (input ce, flush, d, d_vld, output q, q_vld, occ);
endinterface

// File: rtl/dsp_pipe_reg.sv
// dsp_pipe_reg: extend-then-delay operand register, 0..4 stages, with per-stage valid, flush and occupancy.
module dsp_pipe_reg #(
    parameter int                   IN_WIDTH  = 18,
    parameter int                   OUT_WIDTH = 18,
    parameter int                   DEPTH     = 1,
    parameter bit                   SIGN_EXT  = 1'b1,
    parameter logic [OUT_WIDTH-1:0] RSTVAL    = '0,
    localparam int                  OCC_W     = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input logic           clk,
    input logic           rst,
    dsp_pipe_reg_if.slave bus
);
    if (OUT_WIDTH < IN_WIDTH || DEPTH < 0 || DEPTH > 4) begin : g_bad_param
        $error("dsp_pipe_reg: need OUT_WIDTH >= IN_WIDTH and DEPTH in 0..4");
    end
    logic [OUT_WIDTH-1:0] ext;
    assign ext = SIGN_EXT ? OUT_WIDTH'($signed(bus.d)) : OUT_WIDTH'(bus.d);
    if (DEPTH == 0) begin : g_bypass
        assign bus.q     = ext;
        assign bus.q_vld = bus.d_vld;
        assign bus.occ   = '0;
    end else begin : g_pipe
        logic [OUT_WIDTH-1:0] data [DEPTH];
        logic [DEPTH-1:0]     vld;
        logic [OCC_W-1:0]     cnt;
        // Data shifts on every enabled edge regardless of valid; only vld/cnt track operands.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) data[k] <= RSTVAL;
                vld <= '0;
                cnt <= '0;
            end else if (bus.flush) begin
                vld <= '0;
                cnt <= '0;
            end else if (bus.ce) begin
                data[0] <= ext;
                vld[0]  <= bus.d_vld;
                for (int k = 1; k < DEPTH; k++) begin
                    data[k] <= data[k-1];
                    vld[k]  <= vld[k-1];
                end
                cnt <= cnt + OCC_W'(bus.d_vld) - OCC_W'(vld[DEPTH-1]);
            end
        end
        assign bus.q     = data[DEPTH-1];
        assign bus.q_vld = vld[DEPTH-1];
        assign bus.occ   = cnt;
    end
endmodule

// File: tb/tb_dsp_pipe_reg.sv
// tb_dsp_pipe_reg: directed vectors across depth 0/1/2/3/4 and sign/zero extension configurations.
module tb_dsp_pipe_reg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ce, flush, dv;
    logic [17:0] d;
    int checks = 0;
    int errors = 0;

    dsp_pipe_reg_if #(.IN_WIDTH(18), .OUT_WIDTH(18), .OCC_W(2)) i3 ();
    dsp_pipe_reg_if #(.IN_WIDTH(18), .OUT_WIDTH(18), .OCC_W(2)) i2 ();
    dsp_pipe_reg_if #(.IN_WIDTH(18), .OUT_WIDTH(18), .OCC_W(3)) i4 ();
    dsp_pipe_reg_if #(.IN_WIDTH(18), .OUT_WIDTH(18), .OCC_W(1)) i0 ();
    dsp_pipe_reg_if #(.IN_WIDTH(18), .OUT_WIDTH(48), .OCC_W(1)) is ();
    dsp_pipe_reg_if #(.IN_WIDTH(18), .OUT_WIDTH(48), .OCC_W(1)) iz ();

    assign {i3.ce, i3.flush, i3.d, i3.d_vld} = {ce, flush, d, dv};
    assign {i2.ce, i2.flush, i2.d, i2.d_vld} = {ce, flush, d, dv};
    assign {i4.ce, i4.flush, i4.d, i4.d_vld} = {ce, flush, d, dv};
    assign {i0.ce, i0.flush, i0.d, i0.d_vld} = {ce, flush, d, dv};
    assign {is.ce, is.flush, is.d, is.d_vld} = {ce, flush, d, dv};
    assign {iz.ce, iz.flush, iz.d, iz.d_vld} = {ce, flush, d, dv};

    dsp_pipe_reg #(.DEPTH(3), .RSTVAL(18'h00ABC)) u3 (.clk(clk), .rst(rst), .bus(i3));
    dsp_pipe_reg #(.DEPTH(2)) u2 (.clk(clk), .rst(rst), .bus(i2));
    dsp_pipe_reg #(.DEPTH(4), .RSTVAL(18'h00123)) u4 (.clk(clk), .rst(rst), .bus(i4));
    dsp_pipe_reg #(.DEPTH(0)) u0 (.clk(clk), .rst(rst), .bus(i0));
    dsp_pipe_reg #(.OUT_WIDTH(48), .DEPTH(1), .SIGN_EXT(1'b1)) us (.clk(clk), .rst(rst), .bus(is));
    dsp_pipe_reg #(.OUT_WIDTH(48), .DEPTH(1), .SIGN_EXT(1'b0)) uz (.clk(clk), .rst(rst), .bus(iz));

    typedef struct {
        logic        rst, ce, flush;
        logic [17:0] d;
        logic        dv;
        logic [17:0] q;
        logic        qv;
        logic [1:0]  occ;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic f, input logic [17:0] dd, input logic v);
        rst = r; ce = c; flush = f; d = dd; dv = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        //          rst ce fl d          dv  q          qv occ
        tbl[0]  = '{1, 1, 0, 18'h3FFFF, 1, 18'h00ABC, 0, 2'd0};
        tbl[1]  = '{1, 1, 0, 18'h3FFFF, 1, 18'h00ABC, 0, 2'd0};
        tbl[2]  = '{0, 1, 0, 18'h00001, 1, 18'h00ABC, 0, 2'd1};
        tbl[3]  = '{0, 1, 0, 18'h00002, 1, 18'h00ABC, 0, 2'd2};
        tbl[4]  = '{0, 1, 0, 18'h00003, 1, 18'h00001, 1, 2'd3};
        tbl[5]  = '{0, 1, 0, 18'h00004, 1, 18'h00002, 1, 2'd3};
        tbl[6]  = '{0, 1, 0, 18'h00000, 0, 18'h00003, 1, 2'd2};
        tbl[7]  = '{0, 1, 0, 18'h00000, 0, 18'h00004, 1, 2'd1};
        tbl[8]  = '{0, 1, 0, 18'h00000, 0, 18'h00000, 0, 2'd0};
        tbl[9]  = '{0, 1, 0, 18'h00000, 0, 18'h00000, 0, 2'd0};
        tbl[10] = '{0, 1, 0, 18'h00009, 1, 18'h00000, 0, 2'd1};
        tbl[11] = '{0, 0, 0, 18'h00005, 1, 18'h00000, 0, 2'd1};
        tbl[12] = '{0, 1, 0, 18'h00006, 1, 18'h00000, 0, 2'd2};
        tbl[13] = '{0, 1, 0, 18'h00007, 0, 18'h00009, 1, 2'd2};
        tbl[14] = '{0, 1, 1, 18'h00077, 1, 18'h00009, 0, 2'd0};
        tbl[15] = '{1, 0, 1, 18'h00000, 0, 18'h00ABC, 0, 2'd0};
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].ce, tbl[i].flush, tbl[i].d, tbl[i].dv);
            step();
            chk($sformatf("d3_q[%0d]", i), 48'(i3.q), 48'(tbl[i].q));
            chk($sformatf("d3_qv[%0d]", i), 48'(i3.q_vld), 48'(tbl[i].qv));
            chk($sformatf("d3_occ[%0d]", i), 48'(i3.occ), 48'(tbl[i].occ));
        end

        // Stall on depth 2: operand held in stage 0 while CE is low.
        drive(1, 1, 0, 0, 0); step();
        drive(0, 1, 0, 18'h00055, 1); step();
        chk("d2_load_qv", 48'(i2.q_vld), 48'd0);
        chk("d2_load_occ", 48'(i2.occ), 48'd1);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("d2_stall_q[%0d]", i), 48'(i2.q), 48'd0);
            chk($sformatf("d2_stall_qv[%0d]", i), 48'(i2.q_vld), 48'd0);
            chk($sformatf("d2_stall_occ[%0d]", i), 48'(i2.occ), 48'd1);
        end
        drive(0, 1, 0, 0, 0); step();
        chk("d2_out_q", 48'(i2.q), 48'h55);
        chk("d2_out_qv", 48'(i2.q_vld), 48'd1);
        chk("d2_out_occ", 48'(i2.occ), 48'd1);

        // Flush on depth 4: valids cleared, data kept, flushed operand discarded.
        drive(1, 1, 0, 0, 0); step();
        chk("d4_rst_q", 48'(i4.q), 48'h123);
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1, 0, 18'(i), 1); step();
        end
        chk("d4_occ3", 48'(i4.occ), 48'd3);
        chk("d4_q_pre", 48'(i4.q), 48'h123);
        drive(0, 1, 1, 18'h00077, 1); step();
        chk("d4_fl_occ", 48'(i4.occ), 48'd0);
        chk("d4_fl_qv", 48'(i4.q_vld), 48'd0);
        chk("d4_fl_q", 48'(i4.q), 48'h123);
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("d4_post_q[%0d]", i), 48'(i4.q), (i == 3) ? 48'd0 : 48'(i + 1));
            chk($sformatf("d4_post_qv[%0d]", i), 48'(i4.q_vld), 48'd0);
            chk($sformatf("d4_post_occ[%0d]", i), 48'(i4.occ), 48'd0);
        end
        drive(1, 1, 1, 18'h00005, 1); step();
        chk("d4_rstfl_q", 48'(i4.q), 48'h123);
        chk("d4_rstfl_qv", 48'(i4.q_vld), 48'd0);
        chk("d4_rstfl_occ", 48'(i4.occ), 48'd0);

        // Extension into 48 bits, depth 1.
        drive(0, 1, 0, 18'h20000, 1); step();
        chk("ext_sign_neg", is.q, 48'hFFFF_FFFE_0000);
        chk("ext_zero_neg", iz.q, 48'h0000_0002_0000);
        chk("ext_qv", 48'(is.q_vld), 48'd1);
        drive(0, 1, 0, 18'h1FFFF, 0); step();
        chk("ext_sign_pos", is.q, 48'h0000_0001_FFFF);
        chk("ext_zero_pos", iz.q, 48'h0000_0001_FFFF);
        chk("ext_qv0", 48'(iz.q_vld), 48'd0);

        // Bypass: depth 0 follows inputs mid-cycle, immune to RST/FLUSH.
        @(negedge clk);
        drive(1, 0, 1, 18'h12345, 1); #1;
        chk("byp_q_a", 48'(i0.q), 48'h12345);
        chk("byp_qv_a", 48'(i0.q_vld), 48'd1);
        chk("byp_occ_a", 48'(i0.occ), 48'd0);
        drive(1, 1, 1, 18'h0AAAA, 0); #1;
        chk("byp_q_b", 48'(i0.q), 48'h0AAAA);
        chk("byp_qv_b", 48'(i0.q_vld), 48'd0);
        step();
        chk("byp_q_c", 48'(i0.q), 48'h0AAAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
